// File: rtl/ysyx_22040750_trap_ctrl.sv
// Trap sequencer: detects ecall/mret/timer at retire, strobes the CSR file for
// one cycle, captures mtvec/mepc and redirects fetch under valid/ready.
module ysyx_22040750_trap_ctrl #(
    parameter int          PC_W        = 32,
    parameter logic [63:0] ECALL_CAUSE = 64'd11,
    parameter logic [63:0] TIMER_CAUSE = 64'h8000_0000_0000_0007
) (
    input  logic            I_sys_clk,
    input  logic            I_rst_n,
    input  logic            I_wb_valid,
    input  logic [PC_W-1:0] I_wb_pc,
    input  logic [PC_W-1:0] I_wb_next_pc,
    input  logic            I_wb_ecall,
    input  logic            I_wb_mret,
    input  logic            I_timer_intr,
    input  logic [63:0]     I_csr_rd_data,
    output logic            O_csr_valid,
    output logic            O_csr_intr_wr,
    output logic            O_csr_intr_rd,
    output logic            O_csr_mret_wr,
    output logic            O_csr_mret_rd,
    output logic [31:0]     O_intr_pc,
    output logic [63:0]     O_intr_no,
    output logic            O_flush,
    output logic            O_redirect_valid,
    output logic [PC_W-1:0] O_redirect_pc,
    input  logic            I_redirect_ready,
    output logic            O_busy
);

    typedef enum logic [1:0] {IDLE, ENTER, RETURN, REDIRECT} state_t;

    state_t          state;
    logic [PC_W-1:0] epc;
    logic [63:0]     cause;
    logic [PC_W-1:0] target;

    logic            idle;
    logic            det_ecall;
    logic            det_mret;
    logic            det_timer;
    logic [PC_W-1:0] mtvec_base;
    logic [PC_W-1:0] enter_target;
    logic            unused_bits;

    // Detection is gated by reset so flush stays low while reset is held.
    assign idle      = (state == IDLE);
    assign det_ecall = I_rst_n & idle & I_wb_valid & I_wb_ecall;
    assign det_mret  = I_rst_n & idle & I_wb_valid & ~I_wb_ecall & I_wb_mret;
    assign det_timer = I_rst_n & idle & I_wb_valid & ~I_wb_ecall & ~I_wb_mret & I_timer_intr;

    assign mtvec_base = {I_csr_rd_data[PC_W-1:2], 2'b00};

    always_comb begin
        enter_target = mtvec_base;
        if (I_csr_rd_data[1:0] == 2'b01 && cause[63])
            enter_target = mtvec_base + PC_W'({cause[5:0], 2'b00});
    end

    assign O_flush       = O_busy | det_ecall | det_mret | det_timer;
    assign O_redirect_pc = target;
    assign unused_bits   = ^{I_csr_rd_data[63:PC_W], cause[62:6]};

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state            <= IDLE;
            epc              <= '0;
            cause            <= '0;
            target           <= '0;
            O_csr_valid      <= 1'b0;
            O_csr_intr_wr    <= 1'b0;
            O_csr_intr_rd    <= 1'b0;
            O_csr_mret_wr    <= 1'b0;
            O_csr_mret_rd    <= 1'b0;
            O_intr_pc        <= '0;
            O_intr_no        <= '0;
            O_redirect_valid <= 1'b0;
            O_busy           <= 1'b0;
        end else begin
            O_csr_valid   <= 1'b0;
            O_csr_intr_wr <= 1'b0;
            O_csr_intr_rd <= 1'b0;
            O_csr_mret_wr <= 1'b0;
            O_csr_mret_rd <= 1'b0;
            O_intr_pc     <= '0;
            O_intr_no     <= '0;
            case (state)
                IDLE: begin
                    if (det_ecall || det_timer) begin
                        epc           <= det_ecall ? I_wb_pc : I_wb_next_pc;
                        cause         <= det_ecall ? ECALL_CAUSE : TIMER_CAUSE;
                        O_intr_pc     <= 32'(det_ecall ? I_wb_pc : I_wb_next_pc);
                        O_intr_no     <= det_ecall ? ECALL_CAUSE : TIMER_CAUSE;
                        O_csr_valid   <= 1'b1;
                        O_csr_intr_wr <= 1'b1;
                        O_csr_intr_rd <= 1'b1;
                        O_busy        <= 1'b1;
                        state         <= ENTER;
                    end else if (det_mret) begin
                        O_csr_valid   <= 1'b1;
                        O_csr_mret_wr <= 1'b1;
                        O_csr_mret_rd <= 1'b1;
                        O_busy        <= 1'b1;
                        state         <= RETURN;
                    end
                end
                ENTER: begin
                    target           <= enter_target;
                    O_redirect_valid <= 1'b1;
                    state            <= REDIRECT;
                end
                RETURN: begin
                    target           <= I_csr_rd_data[PC_W-1:0];
                    O_redirect_valid <= 1'b1;
                    state            <= REDIRECT;
                end
                REDIRECT: begin
                    if (I_redirect_ready) begin
                        O_redirect_valid <= 1'b0;
                        O_busy           <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040750_trap_ctrl.sv
// Directed self-checking bench for the trap sequencer.
module tb_ysyx_22040750_trap_ctrl;

    logic        I_sys_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        I_wb_valid = 1'b0;
    logic [31:0] I_wb_pc = '0;
    logic [31:0] I_wb_next_pc = '0;
    logic        I_wb_ecall = 1'b0;
    logic        I_wb_mret = 1'b0;
    logic        I_timer_intr = 1'b0;
    logic [63:0] I_csr_rd_data = '0;
    logic        I_redirect_ready = 1'b0;
    logic        O_csr_valid, O_csr_intr_wr, O_csr_intr_rd, O_csr_mret_wr, O_csr_mret_rd;
    logic [31:0] O_intr_pc;
    logic [63:0] O_intr_no;
    logic        O_flush, O_redirect_valid, O_busy;
    logic [31:0] O_redirect_pc;

    int checks = 0;
    int errors = 0;

    ysyx_22040750_trap_ctrl #(.PC_W(32)) dut (
        .I_sys_clk(I_sys_clk), .I_rst_n(I_rst_n), .I_wb_valid(I_wb_valid), .I_wb_pc(I_wb_pc),
        .I_wb_next_pc(I_wb_next_pc), .I_wb_ecall(I_wb_ecall), .I_wb_mret(I_wb_mret),
        .I_timer_intr(I_timer_intr), .I_csr_rd_data(I_csr_rd_data), .O_csr_valid(O_csr_valid),
        .O_csr_intr_wr(O_csr_intr_wr), .O_csr_intr_rd(O_csr_intr_rd), .O_csr_mret_wr(O_csr_mret_wr),
        .O_csr_mret_rd(O_csr_mret_rd), .O_intr_pc(O_intr_pc), .O_intr_no(O_intr_no), .O_flush(O_flush),
        .O_redirect_valid(O_redirect_valid), .O_redirect_pc(O_redirect_pc),
        .I_redirect_ready(I_redirect_ready), .O_busy(O_busy)
    );

    always #5 I_sys_clk = ~I_sys_clk;

    task automatic tick();
        @(posedge I_sys_clk);
        #1;
    endtask

    task automatic clear_wb();
        I_wb_valid = 1'b0; I_wb_ecall = 1'b0; I_wb_mret = 1'b0; I_timer_intr = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (O_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", O_busy); end
        checks++; if (O_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", O_flush); end
        checks++; if (O_redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got %b exp 0", O_redirect_valid); end
        checks++; if ({O_csr_valid, O_csr_intr_wr, O_csr_intr_rd, O_csr_mret_wr, O_csr_mret_rd} !== 5'b0) begin errors++; $display("FAIL rst_strobes got %b exp 0", {O_csr_valid, O_csr_intr_wr, O_csr_intr_rd, O_csr_mret_wr, O_csr_mret_rd}); end
        checks++; if (O_intr_no !== 64'd0) begin errors++; $display("FAIL rst_intr_no got %h exp 0", O_intr_no); end
        tick(); tick();
        I_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ecall();
        I_csr_rd_data = 64'h8000_0100;
        I_wb_valid = 1'b1; I_wb_ecall = 1'b1; I_wb_pc = 32'h8000_0010; I_wb_next_pc = 32'h8000_0014;
        #1;
        checks++; if (O_flush !== 1'b1) begin errors++; $display("FAIL ecall_det_flush got %b exp 1", O_flush); end
        checks++; if (O_busy !== 1'b0) begin errors++; $display("FAIL ecall_det_busy got %b exp 0", O_busy); end
        tick(); clear_wb(); #1;
        checks++; if ({O_csr_valid, O_csr_intr_wr, O_csr_intr_rd, O_csr_mret_wr, O_csr_mret_rd} !== 5'b11100) begin errors++; $display("FAIL ecall_enter_strobes got %b exp 11100", {O_csr_valid, O_csr_intr_wr, O_csr_intr_rd, O_csr_mret_wr, O_csr_mret_rd}); end
        checks++; if (O_intr_pc !== 32'h8000_0010) begin errors++; $display("FAIL ecall_intr_pc got %h exp 80000010", O_intr_pc); end
        checks++; if (O_intr_no !== 64'd11) begin errors++; $display("FAIL ecall_intr_no got %h exp b", O_intr_no); end
        checks++; if (O_busy !== 1'b1 || O_flush !== 1'b1) begin errors++; $display("FAIL ecall_enter_busy got %b%b exp 11", O_busy, O_flush); end
        tick();
        checks++; if (O_redirect_valid !== 1'b1) begin errors++; $display("FAIL ecall_rv got %b exp 1", O_redirect_valid); end
        checks++; if (O_redirect_pc !== 32'h8000_0100) begin errors++; $display("FAIL ecall_rpc got %h exp 80000100", O_redirect_pc); end
        checks++; if (O_csr_intr_wr !== 1'b0 || O_intr_pc !== 32'd0) begin errors++; $display("FAIL ecall_redir_intr got %b %h exp 0 0", O_csr_intr_wr, O_intr_pc); end
        I_redirect_ready = 1'b1; #1;
        checks++; if (O_flush !== 1'b1) begin errors++; $display("FAIL ecall_hs_flush got %b exp 1", O_flush); end
        tick(); I_redirect_ready = 1'b0;
        checks++; if (O_redirect_valid !== 1'b0 || O_busy !== 1'b0 || O_flush !== 1'b0) begin errors++; $display("FAIL ecall_idle got %b%b%b exp 000", O_redirect_valid, O_busy, O_flush); end
    endtask

    task automatic test_mret_backpressure();
        int strobes = 0;
        I_csr_rd_data = 64'h8000_0014;
        I_wb_valid = 1'b1; I_wb_mret = 1'b1; I_wb_pc = 32'h8000_0050;
        tick(); clear_wb();
        checks++; if ({O_csr_valid, O_csr_intr_wr, O_csr_intr_rd, O_csr_mret_wr, O_csr_mret_rd} !== 5'b10011) begin errors++; $display("FAIL mret_strobes got %b exp 10011", {O_csr_valid, O_csr_intr_wr, O_csr_intr_rd, O_csr_mret_wr, O_csr_mret_rd}); end
        checks++; if (O_intr_no !== 64'd0) begin errors++; $display("FAIL mret_intr_no got %h exp 0", O_intr_no); end
        tick();
        I_csr_rd_data = 64'h1234_5678;
        I_wb_valid = 1'b1; I_wb_ecall = 1'b1; I_timer_intr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (O_redirect_valid !== 1'b1 || O_redirect_pc !== 32'h8000_0014 || O_flush !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got %b %h %b exp 1 80000014 1", i, O_redirect_valid, O_redirect_pc, O_flush); end
            strobes += int'(O_csr_valid) + int'(O_csr_intr_wr) + int'(O_csr_mret_wr);
            tick();
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL bp_strobes got %0d exp 0", strobes); end
        clear_wb();
        I_redirect_ready = 1'b1; #1;
        checks++; if (O_redirect_valid !== 1'b1 || O_flush !== 1'b1) begin errors++; $display("FAIL bp_hs got %b%b exp 11", O_redirect_valid, O_flush); end
        tick(); I_redirect_ready = 1'b0;
        checks++; if (O_busy !== 1'b0 || O_redirect_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b%b exp 00", O_busy, O_redirect_valid); end
    endtask

    task automatic test_timer_vectored();
        I_csr_rd_data = 64'h8000_0201;
        I_wb_valid = 1'b1; I_timer_intr = 1'b1; I_wb_pc = 32'h8000_001C; I_wb_next_pc = 32'h8000_0020;
        tick(); clear_wb();
        checks++; if (O_intr_pc !== 32'h8000_0020) begin errors++; $display("FAIL tmr_intr_pc got %h exp 80000020", O_intr_pc); end
        checks++; if (O_intr_no !== 64'h8000_0000_0000_0007) begin errors++; $display("FAIL tmr_intr_no got %h exp 8000000000000007", O_intr_no); end
        tick();
        checks++; if (O_redirect_pc !== 32'h8000_021C) begin errors++; $display("FAIL tmr_rpc got %h exp 8000021c", O_redirect_pc); end
        I_redirect_ready = 1'b1; tick(); I_redirect_ready = 1'b0;
    endtask

    task automatic test_priority();
        I_timer_intr = 1'b1; #1;
        checks++; if (O_flush !== 1'b0) begin errors++; $display("FAIL nowb_flush got %b exp 0", O_flush); end
        tick();
        checks++; if (O_busy !== 1'b0 || O_csr_intr_wr !== 1'b0) begin errors++; $display("FAIL nowb_busy got %b%b exp 00", O_busy, O_csr_intr_wr); end
        I_csr_rd_data = 64'h8000_0201;
        I_wb_valid = 1'b1; I_wb_ecall = 1'b1; I_wb_pc = 32'h8000_0030; I_wb_next_pc = 32'h8000_0034;
        tick(); clear_wb();
        checks++; if (O_intr_pc !== 32'h8000_0030 || O_intr_no !== 64'd11) begin errors++; $display("FAIL prio_enter got %h %h exp 80000030 b", O_intr_pc, O_intr_no); end
        tick();
        checks++; if (O_redirect_pc !== 32'h8000_0200) begin errors++; $display("FAIL prio_rpc got %h exp 80000200", O_redirect_pc); end
        I_redirect_ready = 1'b1; tick(); I_redirect_ready = 1'b0;
    endtask

    task automatic test_back_to_back_wrap();
        I_csr_rd_data = 64'hFFFF_FFFD;
        I_wb_valid = 1'b1; I_timer_intr = 1'b1; I_wb_next_pc = 32'h0000_0100;
        tick(); clear_wb(); tick();
        checks++; if (O_redirect_pc !== 32'h0000_0018) begin errors++; $display("FAIL wrap_rpc got %h exp 00000018", O_redirect_pc); end
        I_redirect_ready = 1'b1; tick(); I_redirect_ready = 1'b0;
        I_wb_valid = 1'b1; I_wb_mret = 1'b1; I_csr_rd_data = 64'h8000_0400;
        tick(); clear_wb();
        checks++; if (O_csr_mret_wr !== 1'b1 || O_busy !== 1'b1) begin errors++; $display("FAIL b2b_mret got %b%b exp 11", O_csr_mret_wr, O_busy); end
        tick();
        checks++; if (O_redirect_pc !== 32'h8000_0400) begin errors++; $display("FAIL b2b_rpc got %h exp 80000400", O_redirect_pc); end
        I_redirect_ready = 1'b1; tick(); I_redirect_ready = 1'b0;
    endtask

    task automatic test_reset_mid_redirect();
        I_csr_rd_data = 64'h8000_0100;
        I_wb_valid = 1'b1; I_wb_ecall = 1'b1; I_wb_pc = 32'h8000_0060;
        tick(); clear_wb(); tick();
        checks++; if (O_redirect_valid !== 1'b1) begin errors++; $display("FAIL mid_rv got %b exp 1", O_redirect_valid); end
        #2 I_rst_n = 1'b0;
        #1;
        checks++; if (O_redirect_valid !== 1'b0 || O_busy !== 1'b0 || O_flush !== 1'b0 || O_redirect_pc !== 32'd0) begin errors++; $display("FAIL mid_rst got %b%b%b %h exp 000 0", O_redirect_valid, O_busy, O_flush, O_redirect_pc); end
        tick(); tick();
        I_rst_n = 1'b1;
        tick();
        checks++; if (O_busy !== 1'b0 || O_redirect_valid !== 1'b0 || O_csr_valid !== 1'b0) begin errors++; $display("FAIL mid_after got %b%b%b exp 000", O_busy, O_redirect_valid, O_csr_valid); end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret_backpressure();
        test_timer_vectored();
        test_priority();
        test_back_to_back_wrap();
        test_reset_mid_redirect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040750_trap_ctrl.md
Name: ysyx_22040750_trap_ctrl

Overview:
- Trap sequencer between the MEM/WB retire point, the CSR file and the fetch redirect path.
- Detects ecall, mret and a pending machine-timer interrupt at the retire boundary.
- Drives the CSR file's trap-entry and trap-return write/read strobes for exactly one cycle, and captures the target PC (mtvec or mepc).
- Flushes the pipeline and issues a redirect to fetch under a valid/ready handshake.

Parameters:
- PC_W, 32, width of pc and redirect target.
- ECALL_CAUSE, 64'd11, mcause value written for ecall from M-mode.
- TIMER_CAUSE, 64'h8000_0000_0000_0007, mcause value written for machine-timer interrupt.

Ports:
- I_sys_clk  in  1  clock.
- I_rst_n  in  1  asynchronous active-low reset.
- I_wb_valid  in  1  instruction retiring in MEM/WB this cycle.
- I_wb_pc  in  PC_W  pc of retiring instruction.
- I_wb_next_pc  in  PC_W  architectural next pc of retiring instruction.
- I_wb_ecall  in  1  retiring instruction is ecall.
- I_wb_mret  in  1  retiring instruction is mret.
- I_timer_intr  in  1  CSR file timer-interrupt output (mip.MTIP & mie.MTIE & mstatus.MIE).
- I_csr_rd_data  in  64  CSR file combinational read data.
- O_csr_valid  out  1  qualifies CSR writes (CSR file MEM_WB_valid input).
- O_csr_intr_wr  out  1  trap-entry write strobe.
- O_csr_intr_rd  out  1  select mtvec on CSR read port.
- O_csr_mret_wr  out  1  trap-return write strobe.
- O_csr_mret_rd  out  1  select mepc on CSR read port.
- O_intr_pc  out  32  value for mepc.
- O_intr_no  out  64  value for mcause.
- O_flush  out  1  kill IF..MEM, suppress retire.
- O_redirect_valid  out  1  redirect request to fetch.
- O_redirect_pc  out  PC_W  redirect target.
- I_redirect_ready  in  1  fetch accepts redirect.
- O_busy  out  1  FSM not IDLE.

Behaviour:
- FSM states: IDLE, ENTER, RETURN, REDIRECT.
- Reset (async, I_rst_n=0): state=IDLE; all outputs 0; captured epc/cause/target registers 0. Reset asserted in any state aborts the sequence, with no CSR strobe in that or later cycles.
- IDLE: detection is combinational on inputs, with priority ecall > mret > timer.
  - I_wb_valid & I_wb_ecall: capture epc=I_wb_pc, cause=ECALL_CAUSE; next state ENTER.
  - Else I_wb_valid & I_wb_mret: next state RETURN.
  - Else I_wb_valid & I_timer_intr: retiring instruction completes; capture epc=I_wb_next_pc, cause=TIMER_CAUSE; next state ENTER.
  - Timer is never taken without a retiring instruction. Timer pending together with ecall/mret: ecall/mret wins; timer is re-evaluated at a later retire.
  - O_flush asserts combinationally in the detection cycle.
- ENTER (1 cycle): O_csr_valid=1, O_csr_intr_wr=1, O_csr_intr_rd=1, O_intr_pc=epc[31:0], O_intr_no=cause.
  - Latch target from I_csr_rd_data (old mtvec; mtvec is unaffected by the write).
  - Direct mode (mtvec[1:0]!=1), or cause MSB=0: target={mtvec[PC_W-1:2],2'b00}.
  - Vectored mode (mtvec[1:0]==1) with cause MSB=1: target={mtvec[PC_W-1:2],2'b00}+4*cause[5:0], truncated to PC_W (wrap).
  - Next state REDIRECT.
- RETURN (1 cycle): O_csr_valid=1, O_csr_mret_wr=1, O_csr_mret_rd=1; latch target=I_csr_rd_data[PC_W-1:0] (mepc). Next state REDIRECT.
- REDIRECT:
  - O_redirect_valid=1, O_redirect_pc=target; both held stable until I_redirect_ready.
  - In the handshake cycle, return to IDLE. O_redirect_valid deasserts next cycle.
- O_flush=1 in the detection cycle and in ENTER, RETURN and REDIRECT, including the handshake cycle. O_busy=1 in all non-IDLE states.
- While busy, I_wb_* and I_timer_intr are ignored.
- CSR strobes are mutually exclusive and each is 1 cycle per trap. O_intr_pc/O_intr_no are 0 outside ENTER.
- Minimum trap latency: detect cycle -> ENTER -> REDIRECT = redirect valid 2 cycles after detection.

Test Plan:
- Ecall: wb_valid, ecall, wb_pc=0x8000_0010, mtvec CSR data 0x8000_0100 -> ENTER cycle intr_wr=1, intr_pc=0x8000_0010, intr_no=11; redirect_pc=0x8000_0100; returns to IDLE on ready.
- Mret: wb_valid, mret, mepc read 0x8000_0014 -> single mret_wr/mret_rd pulse; redirect_pc=0x8000_0014; no intr_wr.
- Timer vectored: timer_intr=1, wb_valid, next_pc=0x8000_0020, mtvec=0x8000_0201 -> intr_pc=0x8000_0020, intr_no=0x8000_0000_0000_0007, redirect_pc=0x8000_021C.
- Priority: ecall and timer_intr simultaneous -> cause=11, epc=wb_pc. Timer without wb_valid -> no action, busy=0.
- Backpressure: ready low 5 cycles -> redirect_valid and pc stable, flush high, no repeated CSR strobes; handshake -> IDLE next cycle.
- Reset mid-REDIRECT: I_rst_n low -> all outputs 0 immediately; after release, IDLE and no redirect.
